// File: rtl/sfifo_pkg.sv
// Shared constants and types for the single-clock parametrised FIFO.
package sfifo_pkg;

  localparam int SFIFO_DATA_W = 8;
  localparam int SFIFO_DEPTH  = 16;

  // Occupancy/threshold width: must represent 0..depth inclusive.
  function automatic int cnt_w_f(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  // Count/threshold type at the default depth, for benches and wrappers.
  typedef logic [cnt_w_f(SFIFO_DEPTH)-1:0] sfifo_cnt_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_param: synchronous write port, read port that is
// registered by default or combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; the read strobe and reset are not needed here.
  assign rdata = mem_r[raddr];

  logic unused_s;
  assign unused_s = &{1'b0, re, clear_n};
`else
  logic [DATA_W-1:0] rdata_r;

  // Registered read: output updates only on an accepted read, else holds.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost thresholds,
// occupancy count and sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo_param
  import sfifo_pkg::*;
#(
  parameter  int DATA_W = SFIFO_DATA_W,
  parameter  int DEPTH  = SFIFO_DEPTH,
  localparam int CNT_W  = cnt_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [CNT_W-1:0]  af_thresh,
  input  logic [CNT_W-1:0]  ae_thresh,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              almost_full,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              empty,
  output logic              almost_empty,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [CNT_W-1:0]  data_count,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic full_r, empty_r, af_r, ae_r;
  logic wr_ack_r, wr_err_r, rd_ack_r, rd_err_r, ovf_r, udf_r;
  logic wr_acc_s, wr_rej_s, rd_acc_s, rd_rej_s;

  // Request qualification against registered flags and next-count selection.
  always_comb begin
    wr_acc_s = wr_en && !full_r;
    wr_rej_s = wr_en && full_r;
    rd_acc_s = rd_en && !empty_r;
    rd_rej_s = rd_en && empty_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_next_s = cnt_r + CNT_ONE;
      2'b01:   cnt_next_s = cnt_r - CNT_ONE;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Pointer advance on accepted transfers; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_ONE;
      end
    end
  end

  // Count and flags share one edge; flags re-evaluate thresholds every cycle.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      cnt_r   <= cnt_next_s;
      full_r  <= (cnt_next_s == DEPTH_C);
      empty_r <= (cnt_next_s == '0);
      af_r    <= (cnt_next_s >= af_thresh);
      ae_r    <= (cnt_next_s <= ae_thresh);
    end
  end

  // Per-request handshake pulses and sticky error capture.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ack_r <= 1'b0;
      wr_err_r <= 1'b0;
      rd_ack_r <= 1'b0;
      rd_err_r <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      wr_ack_r <= wr_acc_s;
      wr_err_r <= wr_rej_s;
      rd_ack_r <= rd_acc_s;
      rd_err_r <= rd_rej_s;
      if (wr_rej_s) begin
        ovf_r <= 1'b1;
      end
      if (rd_rej_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .clear_n (clear_n),
    .we      (wr_acc_s),
    .waddr   (wr_ptr_r),
    .wdata   (din),
    .re      (rd_acc_s),
    .raddr   (rd_ptr_r),
    .rdata   (dout)
  );

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign wr_ack       = wr_ack_r;
  assign wr_err       = wr_err_r;
  assign rd_ack       = rd_ack_r;
  assign rd_err       = rd_err_r;
  assign data_count   = cnt_r;
  assign ovf_sticky   = ovf_r;
  assign udf_sticky   = udf_r;

endmodule
